// File: rtl/dnn_ctrl_pkg.sv
// Shared types and sizing helpers for the junction sequencing controllers.
package dnn_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FF    = 3'd1,
    ST_DRAIN = 3'd2,
    ST_BPUP  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  // Cycles per sample pass: weights of one junction streamed z at a time.
  function automatic int unsigned cpc_f(input int unsigned p, input int unsigned fo,
                                        input int unsigned z);
    return (p * fo) / z;
  endfunction

  function automatic int unsigned idx_w_f(input int unsigned cpc);
    return (cpc > 1) ? $clog2(cpc) : 1;
  endfunction

  localparam int unsigned DEF_IDX_W = idx_w_f(cpc_f(16, 2, 8));

endpackage

// File: rtl/en_delay_line.sv
// Fixed-depth register chain carrying a strobe and its index alongside a pipelined table.
module en_delay_line #(
  parameter int unsigned depth = 1,
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [width-1:0] in_idx,
  output logic             out_vld,
  output logic [width-1:0] out_idx,
  output logic             pending_c
);

  // Stages that will still reach the output after the current cycle.
  localparam logic [depth-1:0] PEND_MASK = {depth{1'b1}} >> 1;

  logic [depth-1:0] vld_q;
  logic [width-1:0] idx_q [depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(depth); i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int i = 1; i < int'(depth); i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_vld   = vld_q[depth-1];
  assign out_idx   = idx_q[depth-1];
  assign pending_c = |(vld_q & PEND_MASK);

endmodule

// File: rtl/junction_scheduler.sv
// Sequences forward, drain and backprop/update passes for one junction's processor sets.
module junction_scheduler
  import dnn_ctrl_pkg::*;
#(
  parameter int unsigned fo      = 2,
  parameter int unsigned fi      = 4,
  parameter int unsigned p       = 16,
  parameter int unsigned n       = 8,
  parameter int unsigned z       = 8,
  parameter int unsigned sig_lat = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   infer,
  input  logic                                   stall,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   ff_en,
  output logic [idx_w_f(cpc_f(p, fo, z))-1:0]    ff_idx,
  output logic                                   act_wr_en,
  output logic [idx_w_f(cpc_f(p, fo, z))-1:0]    act_wr_idx,
  output logic                                   bpup_en,
  output logic [idx_w_f(cpc_f(p, fo, z))-1:0]    bpup_idx
);

  localparam int unsigned CPC   = cpc_f(p, fo, z);
  localparam int unsigned IDX_W = idx_w_f(CPC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CPC - 1);

  if ((p * fo != n * fi) || ((p * fo) % z != 0) || (CPC < 2) || (sig_lat < 1)) begin : g_illegal
    $error("junction_scheduler: illegal geometry (p*fo must equal n*fi, cpc integer >= 2, sig_lat >= 1)");
  end

  sched_state_t     state, state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx;
  logic             infer_q, infer_nx;
  logic [IDX_W-1:0] dly_idx;
  logic             pending_c;

  // Next state, phase counter and the stall-gated issue strobes.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    infer_nx = infer_q;
    ff_en    = 1'b0;
    bpup_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_FF;
          cnt_nx   = '0;
          infer_nx = infer;
        end
      end
      ST_FF: begin
        if (!stall) begin
          ff_en = 1'b1;
          if (cnt == LAST_IDX) begin
            state_nx = ST_DRAIN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + IDX_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!pending_c) state_nx = infer_q ? ST_DONE : ST_BPUP;
      end
      ST_BPUP: begin
        if (!stall) begin
          bpup_en = 1'b1;
          if (cnt == LAST_IDX) begin
            state_nx = ST_DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + IDX_W'(1);
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      infer_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      infer_q <= infer_nx;
      busy    <= (state_nx == ST_FF) || (state_nx == ST_DRAIN) || (state_nx == ST_BPUP);
      done    <= (state_nx == ST_DONE);
    end
  end

  assign ff_idx   = cnt;
  assign bpup_idx = cnt;
  assign dly_idx  = ff_en ? cnt : '0;

  en_delay_line #(
    .depth (sig_lat),
    .width (IDX_W)
  ) u_act_dly (
    .clk       (clk),
    .reset     (reset),
    .in_vld    (ff_en),
    .in_idx    (dly_idx),
    .out_vld   (act_wr_en),
    .out_idx   (act_wr_idx),
    .pending_c (pending_c)
  );

endmodule

// File: tb/tb_junction_scheduler.sv
// Randomized scoreboard bench for junction_scheduler against a pass-timeline reference model.
module tb_junction_scheduler;

  localparam int CPC     = 4;
  localparam int SIG_LAT = 1;
  localparam int IW      = 2;
  localparam int MAXC    = 4000;
  localparam int N_RAND  = 40;

  typedef struct {
    int cyc;
    int idx;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset, start, infer, stall;
  logic          busy, done, ff_en, act_wr_en, bpup_en;
  logic [IW-1:0] ff_idx, act_wr_idx, bpup_idx;

  junction_scheduler #(
    .fo(2), .fi(4), .p(16), .n(8), .z(8), .sig_lat(SIG_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .infer      (infer),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .ff_en      (ff_en),
    .ff_idx     (ff_idx),
    .act_wr_en  (act_wr_en),
    .act_wr_idx (act_wr_idx),
    .bpup_en    (bpup_en),
    .bpup_idx   (bpup_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit  reset_plan [MAXC];
  bit  start_plan [MAXC];
  bit  infer_plan [MAXC];
  bit  stall_plan [MAXC];
  bit  busy_exp   [MAXC];
  bit  quiet_exp  [MAXC];
  ev_t evq [4][$];
  int  done_seen [$];
  int  end_cyc = MAXC - 1;
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s at cycle %0d: actual=%0d required=%0d", nm, cyc, act, req);
  endtask

  // Reference: a pass issues cpc FF beats on the first non-stalled cycles after start,
  // table writes follow each beat by sig_lat, BPUP beats begin right after the last write.
  task automatic plan_pass(input int s, input bit inf, output int done_c);
    int t;
    t = s + 1;
    for (int k = 0; k < CPC; k++) begin
      while (stall_plan[t] && t < MAXC - 1) t++;
      evq[0].push_back('{t, k});
      evq[1].push_back('{t + SIG_LAT, k});
      t++;
    end
    t = t - 1 + SIG_LAT + 1;
    if (!inf) begin
      for (int k = 0; k < CPC; k++) begin
        while (stall_plan[t] && t < MAXC - 1) t++;
        evq[2].push_back('{t, k});
        t++;
      end
    end
    evq[3].push_back('{t, 0});
    done_c = t;
    for (int c = s + 1; c < t; c++) busy_exp[c] = 1'b1;
  endtask

  task automatic abort_after(input int r, input int d);
    for (int k = 0; k < 4; k++)
      while (evq[k].size() > 0 && evq[k][$].cyc > r) void'(evq[k].pop_back());
    for (int c = r + 1; c <= d; c++) busy_exp[c] = 1'b0;
    quiet_exp[r + 1] = 1'b1;
  endtask

  // Drive the planned inputs for the new cycle just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (cyc < MAXC) begin
      reset = reset_plan[cyc];
      start = start_plan[cyc];
      infer = infer_plan[cyc];
      stall = stall_plan[cyc];
    end
  end

  // Monitor: pop expected events whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < end_cyc) begin
      bit   en [4];
      int   iv [4];
      string nm [4];
      ev_t  e;
      en = '{ff_en, act_wr_en, bpup_en, done};
      iv = '{int'(ff_idx), int'(act_wr_idx), int'(bpup_idx), 0};
      nm = '{"ff", "act_wr", "bpup", "done"};
      for (int k = 0; k < 4; k++) begin
        if (en[k]) begin
          if (evq[k].size() == 0) begin
            chk({"unexpected_", nm[k]}, 1, 0);
          end else begin
            e = evq[k].pop_front();
            chk({nm[k], "_cycle"}, cyc, e.cyc);
            chk({nm[k], "_idx"}, iv[k], e.idx);
          end
        end else if (evq[k].size() > 0 && evq[k][0].cyc <= cyc) begin
          e = evq[k].pop_front();
          chk({"missing_", nm[k]}, 0, 1);
        end
      end
      chk("busy", int'(busy), int'(busy_exp[cyc]));
      if (quiet_exp[cyc])
        chk("quiet_outputs",
            int'({busy, done, ff_en, ff_idx, act_wr_en, act_wr_idx, bpup_en, bpup_idx}), 0);
      if (done) done_seen.push_back(cyc);
    end
  end

  initial begin
    int d, cur, s;
    bit inf;
    int dir_done [5];
    dir_done = '{30, 46, 72, 90, 119};

    for (int c = 0; c < 3; c++) reset_plan[c] = 1'b1;
    for (int c = 1; c <= 13; c++) quiet_exp[c] = 1'b1;
    stall_plan[5] = 1'b1; stall_plan[6] = 1'b1;
    stall_plan[25] = 1'b1; stall_plan[30] = 1'b1; stall_plan[50] = 1'b1;
    for (int c = 131; c < MAXC; c++) begin
      stall_plan[c] = ($urandom_range(0, 3) == 0);
      infer_plan[c] = $urandom_range(0, 1) == 1;
    end

    start_plan[20] = 1'b1; plan_pass(20, 1'b0, d);
    start_plan[40] = 1'b1; infer_plan[40] = 1'b1; plan_pass(40, 1'b1, d);
    stall_plan[62] = 1'b1; stall_plan[63] = 1'b1;
    start_plan[60] = 1'b1; plan_pass(60, 1'b0, d);
    start_plan[80] = 1'b1; plan_pass(80, 1'b0, d);
    start_plan[83] = 1'b1; start_plan[90] = 1'b1;
    start_plan[100] = 1'b1; plan_pass(100, 1'b0, d);
    reset_plan[107] = 1'b1; abort_after(107, d);
    start_plan[109] = 1'b1; plan_pass(109, 1'b0, d);

    cur = 130;
    for (int i = 0; i < N_RAND; i++) begin
      s = cur + int'($urandom_range(0, 3));
      inf = $urandom_range(0, 1) == 1;
      start_plan[s] = 1'b1;
      infer_plan[s] = inf;
      plan_pass(s, inf, d);
      for (int c = s + 1; c <= d; c++) if ($urandom_range(0, 3) == 0) start_plan[c] = 1'b1;
      cur = d + 1;
    end
    end_cyc = cur + 5;

    reset = reset_plan[0];
    start = start_plan[0];
    infer = infer_plan[0];
    stall = stall_plan[0];

    wait (cyc >= end_cyc);
    @(posedge clk);
    for (int k = 0; k < 4; k++) chk("leftover_events", evq[k].size(), 0);
    chk("done_count", done_seen.size(), 5 + N_RAND);
    for (int i = 0; i < 5; i++)
      if (i < done_seen.size()) chk("directed_done_cycle", done_seen[i], dir_done[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
